countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- MM:SS countdown timer built from cascaded BCD digits.
- Counts down and borrows between digits: seconds-units mod 10, seconds-tens mod 6, minutes-units mod 10, minutes-tens mod 10.
- This is the down-counting counterpart of our mod-6/mod-10 up-counter chain with carry-out. It is used for kitchen-timer and stopwatch-countdown features.
- It owns its own prescaler, run/pause state machine and expiry signalling.

Parameters:
- TICK_DIV, default 1000: clock cycles per one-second decrement tick. Must be ≥2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  load ld_* digits (one-cycle strobe).
- ld_m10  in  4  BCD minutes tens to load.
- ld_m1  in  4  BCD minutes units to load.
- ld_s10  in  4  BCD seconds tens to load.
- ld_s1  in  4  BCD seconds units to load.
- start  in  1  start or resume request (strobe).
- pause  in  1  pause request (strobe).
- m10, m1, s10, s1  out  4 each  current time digits (registered).
- running  out  1  high while in RUN.
- expired  out  1  high while in EXPIRED.
- done  out  1  one-cycle pulse on reaching 00:00.

Behaviour:
- States: IDLE, RUN, PAUSED, EXPIRED.
- Reset values: all digits 0, state IDLE, prescaler 0, running 0, expired 0, done 0.
- Priority per cycle: reset > load > start/pause > tick.
- Load:
  - Accepted in every state.
  - Clamps each digit: s10 > 5 becomes 5; any other digit > 9 becomes 9.
  - Goes to IDLE, clears the prescaler, expired and done.
  - New digits are visible on the next cycle.
- IDLE:
  - start with a loaded time ≠ 00:00 → RUN.
  - start with 00:00 → ignored, stays in IDLE.
  - pause → ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1.
  - The tick is the cycle in which the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - The first decrement lands exactly TICK_DIV cycles after the start edge.
  - pause → PAUSED; it takes precedence over start in the same cycle.
  - Pause and tick in the same cycle: pause wins, no decrement, prescaler holds at TICK_DIV-1.
- PAUSED:
  - Prescaler and digits hold.
  - start → RUN; the prescaler resumes from its held value. It is not cleared.
  - pause → ignored.
- Decrement on tick (one cycle, all digits updated together):
  - s1 -1. If s1 was 0 → s1 = 9 and borrow to s10.
  - s10 -1 on borrow. If it was 0 → s10 = 5 and borrow to m1.
  - m1 -1 on borrow. If it was 0 → m1 = 9 and borrow to m10.
  - m10 -1 on borrow.
- Expiry:
  - If a decrement produces 00:00, the same edge moves the state to EXPIRED and sets done = 1.
  - done, expired and the 00:00 digits all appear in the same cycle.
  - done is high for exactly one cycle; expired stays high.
- Underflow is impossible: no tick is ever processed in EXPIRED or IDLE.
- EXPIRED:
  - start and pause are ignored.
  - Only load or reset leave this state.
- Reset mid-run: the next cycle shows the full reset values; no done pulse is generated.
- Outputs:
  - running = (state == RUN); expired = (state == EXPIRED). Both are registered state decodes.
  - Digits are always valid BCD, s10 ≤ 5.

Test Plan (TICK_DIV = 4):
- Reset: assert reset for 2 cycles → digits 00:00, running 0, expired 0, done 0.
- Full borrow chain: load 10:00, start → 4 cycles later 09:59, running 1. Repeat with 01:00 → 00:59.
- Expiry: load 00:02, start → 00:01 at +4 cycles, 00:00 at +8. done is a 1-cycle pulse at +8, expired 1, running 0. A later start stays expired with no decrement.
- Pause/resume:
  - load 00:05, start, wait 2 cycles, pause.
  - Hold PAUSED 10 cycles → digits stay 00:05.
  - start → 00:04 appears 2 cycles after resume.
  - start+pause together in RUN → PAUSED.
- Load clamp and mid-run load: load ld = 9,15,7,12 → 99:59. During RUN, load 03:30 → IDLE, 03:30, prescaler 0. start with 00:00 loaded → stays IDLE.
- Reset mid-run: load 00:01, start, assert reset on the cycle the tick would fire → 00:00, IDLE, done never asserted.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control/status bundle for the MM:SS countdown timer.
// master drives load/start/pause and the load digits; slave is the timer itself.
interface countdown_timer_if;
    logic       load;
    logic [3:0] ld_m10;
    logic [3:0] ld_m1;
    logic [3:0] ld_s10;
    logic [3:0] ld_s1;
    logic       start;
    logic       pause;
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
    logic       running;
    logic       expired;
    logic       done;

    modport master (
        output load, ld_m10, ld_m1, ld_s10, ld_s1, start, pause,
        input  m10, m1, s10, s1, running, expired, done
    );

    modport slave (
        input  load, ld_m10, ld_m1, ld_s10, ld_s1, start, pause,
        output m10, m1, s10, s1, running, expired, done
    );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS countdown timer: cascaded BCD digits with borrow, an internal one-second
// prescaler, a run/pause FSM and a one-cycle done pulse on reaching 00:00.
module countdown_timer #(
    parameter int TICK_DIV = 1000
) (
    input  logic             clk,
    input  logic             reset,
    countdown_timer_if.slave bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    typedef struct packed {
        logic [3:0] m10;
        logic [3:0] m1;
        logic [3:0] s10;
        logic [3:0] s1;
    } time_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    time_t           time_q, time_d;
    logic            done_q, done_d;
    logic            running_q, expired_q;
    logic            tick;

    function automatic logic [3:0] clamp_digit(logic [3:0] d, logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

    // Borrow ripples from seconds-units up; callers guarantee the input is not 00:00.
    function automatic time_t decrement(time_t t);
        time_t r;
        r = t;
        if (t.s1 != 4'd0) begin
            r.s1 = t.s1 - 4'd1;
        end else begin
            r.s1 = 4'd9;
            if (t.s10 != 4'd0) begin
                r.s10 = t.s10 - 4'd1;
            end else begin
                r.s10 = 4'd5;
                if (t.m1 != 4'd0) begin
                    r.m1 = t.m1 - 4'd1;
                end else begin
                    r.m1  = 4'd9;
                    r.m10 = t.m10 - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign tick = (presc_q == PRESC_MAX);

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        time_d  = time_q;
        done_d  = 1'b0;
        if (bus.load) begin
            time_d.m10 = clamp_digit(bus.ld_m10, 4'd9);
            time_d.m1  = clamp_digit(bus.ld_m1,  4'd9);
            time_d.s10 = clamp_digit(bus.ld_s10, 4'd5);
            time_d.s1  = clamp_digit(bus.ld_s1,  4'd9);
            state_d    = IDLE;
            presc_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && (time_q != '0)) state_d = RUN;
                end
                RUN: begin
                    // Pause beats both start and a coincident tick; the prescaler holds.
                    if (bus.pause) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        presc_d = '0;
                        time_d  = decrement(time_q);
                        if (time_d == '0) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSED: begin
                    if (bus.start) state_d = RUN;
                end
                EXPIRED: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            time_q    <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            time_q    <= time_d;
            done_q    <= done_d;
            running_q <= (state_d == RUN);
            expired_q <= (state_d == EXPIRED);
        end
    end

    assign bus.m10     = time_q.m10;
    assign bus.m1      = time_q.m1;
    assign bus.s10     = time_q.s10;
    assign bus.s1      = time_q.s1;
    assign bus.running = running_q;
    assign bus.expired = expired_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (TICK_DIV = 4): per-cycle vectors with
// hand-derived expectations, queued when driven and compared after the clock edge.
module tb_countdown_timer;

    typedef struct {
        logic        rst;
        logic        load;
        logic [15:0] ld;
        logic        start;
        logic        pause;
        logic [15:0] t;
        logic        run;
        logic        expd;
        logic        dn;
    } vec_t;

    typedef struct packed {
        logic [15:0] t;
        logic        run;
        logic        expd;
        logic        dn;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   row;
    vec_t vecs[$];
    exp_t sb[$];

    countdown_timer_if bus ();

    countdown_timer #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s row %0d: got %h, expected %h", name, idx, act, req);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic ld, input logic [15:0] val,
                                input logic st, input logic ps, input logic [15:0] t,
                                input logic run, input logic ex, input logic dn);
        vec_t v;
        v.rst = r;   v.load = ld;  v.ld = val; v.start = st; v.pause = ps;
        v.t   = t;   v.run  = run; v.expd = ex; v.dn   = dn;
        return v;
    endfunction

    task automatic add(input logic r, input logic ld, input logic [15:0] val,
                       input logic st, input logic ps, input logic [15:0] t,
                       input logic run, input logic ex, input logic dn);
        vecs.push_back(mk(r, ld, val, st, ps, t, run, ex, dn));
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset      = v.rst;
        bus.load   = v.load;
        bus.ld_m10 = v.ld[15:12];
        bus.ld_m1  = v.ld[11:8];
        bus.ld_s10 = v.ld[7:4];
        bus.ld_s1  = v.ld[3:0];
        bus.start  = v.start;
        bus.pause  = v.pause;
        e.t = v.t; e.run = v.run; e.expd = v.expd; e.dn = v.dn;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got.t    = {bus.m10, bus.m1, bus.s10, bus.s1};
        got.run  = bus.running;
        got.expd = bus.expired;
        got.dn   = bus.done;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard row %0d: queue empty, expected one entry", row);
        end else begin
            e = sb.pop_front();
            check("time",    row, got.t, e.t);
            check("running", row, {15'd0, got.run},  {15'd0, e.run});
            check("expired", row, {15'd0, got.expd}, {15'd0, e.expd});
            check("done",    row, {15'd0, got.dn},   {15'd0, e.dn});
        end
        row++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        row    = 0;
        reset  = 1'b1;
        bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
        bus.ld_m10 = '0; bus.ld_m1 = '0; bus.ld_s10 = '0; bus.ld_s1 = '0;

        // Reset for two cycles.
        add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
        add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
        // Full borrow chain 10:00 -> 09:59 four cycles after start.
        add(0, 1, 16'h1000, 0, 0, 16'h1000, 0, 0, 0);
        add(0, 0, 16'h0000, 1, 0, 16'h1000, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 16'h0000, 0, 0, 16'h1000, 1, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 16'h0959, 1, 0, 0);
        // 01:00 -> 00:59, load taken while running.
        add(0, 1, 16'h0100, 0, 0, 16'h0100, 0, 0, 0);
        add(0, 0, 16'h0000, 1, 0, 16'h0100, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 16'h0000, 0, 0, 16'h0100, 1, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 16'h0059, 1, 0, 0);
        // Expiry from 00:02.
        add(0, 1, 16'h0002, 0, 0, 16'h0002, 0, 0, 0);
        add(0, 0, 16'h0000, 1, 0, 16'h0002, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 16'h0000, 0, 0, 16'h0002, 1, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 16'h0001, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 16'h0000, 0, 0, 16'h0001, 1, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
        // Clamp (9,15,7,12 -> 99:59) loaded out of EXPIRED, then mid-run load of 03:30.
        add(0, 1, 16'h9F7C, 0, 0, 16'h9959, 0, 0, 0);
        add(0, 0, 16'h0000, 1, 0, 16'h9959, 1, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 16'h9959, 1, 0, 0);
        add(0, 1, 16'h0330, 0, 0, 16'h0330, 0, 0, 0);
        add(0, 0, 16'h0000, 1, 0, 16'h0330, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 16'h0000, 0, 0, 16'h0330, 1, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 16'h0329, 1, 0, 0);
        // Start with 00:00 loaded stays in IDLE.
        add(0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0);
        add(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // Pause/resume: pause with the prescaler at 2, hold, resume, decrement two cycles later.
        apply(mk(0, 1, 16'h0005, 0, 0, 16'h0005, 0, 0, 0));
        apply(mk(0, 0, 16'h0000, 1, 0, 16'h0005, 1, 0, 0));
        apply(mk(0, 0, 16'h0000, 0, 0, 16'h0005, 1, 0, 0));
        apply(mk(0, 0, 16'h0000, 0, 0, 16'h0005, 1, 0, 0));
        apply(mk(0, 0, 16'h0000, 0, 1, 16'h0005, 0, 0, 0));
        for (int i = 0; i < 10; i++) apply(mk(0, 0, 16'h0000, 0, 0, 16'h0005, 0, 0, 0));
        apply(mk(0, 0, 16'h0000, 0, 1, 16'h0005, 0, 0, 0));
        apply(mk(0, 0, 16'h0000, 1, 0, 16'h0005, 1, 0, 0));
        apply(mk(0, 0, 16'h0000, 0, 0, 16'h0005, 1, 0, 0));
        apply(mk(0, 0, 16'h0000, 0, 0, 16'h0004, 1, 0, 0));
        // Pause on the tick cycle: no decrement, prescaler held at its last value.
        for (int i = 0; i < 3; i++) apply(mk(0, 0, 16'h0000, 0, 0, 16'h0004, 1, 0, 0));
        apply(mk(0, 0, 16'h0000, 0, 1, 16'h0004, 0, 0, 0));
        apply(mk(0, 0, 16'h0000, 1, 0, 16'h0004, 1, 0, 0));
        apply(mk(0, 0, 16'h0000, 0, 0, 16'h0003, 1, 0, 0));
        // start and pause together in RUN: pause wins.
        apply(mk(0, 0, 16'h0000, 1, 1, 16'h0003, 0, 0, 0));
        apply(mk(0, 0, 16'h0000, 0, 0, 16'h0003, 0, 0, 0));

        // Reset on the cycle the final tick would fire: no done pulse.
        apply(mk(0, 1, 16'h0001, 0, 0, 16'h0001, 0, 0, 0));
        apply(mk(0, 0, 16'h0000, 1, 0, 16'h0001, 1, 0, 0));
        for (int i = 0; i < 3; i++) apply(mk(0, 0, 16'h0000, 0, 0, 16'h0001, 1, 0, 0));
        apply(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0));
        for (int i = 0; i < 3; i++) apply(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
